texture_load_ctrl: RTL
======================

Name: texture_load_ctrl

Overview:
- Sequences the one-time texture load into the sprite renderer's three texture RAMs: bird (3 animation frames), pipe and base (ground).
- Issues one burst-read request per texture to the SDRAM read port, accepts the returned 16-bit word stream over valid/ready, and drives the renderer's per-texture write-enable, address and shared data bus.
- Sits between the SDRAM reader and sprite_render; its tex_ready flag gates game start.

Parameters:
- BIRD_WORDS, 5250, words in bird texture (3 frames × 50×35).
- PIPE_WORDS, 40000, words in pipe source image (80×500); all are consumed.
- PIPE_KEEP, 4000, leading pipe words actually written (first 50 rows).
- BASE_WORDS, 9600, words in base texture (64×150).
- BIRD_SRC_ADDR, 24'h100000, SDRAM word address of bird image.
- PIPE_SRC_ADDR, 24'h102000, SDRAM word address of pipe image.
- BASE_SRC_ADDR, 24'h10C000, SDRAM word address of base image.
- TIMEOUT_CYC, 1000000, max idle cycles waiting for rd_ack or src_valid.

Ports:
- clk  in  1  system clock (50 MHz load domain).
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse: begin a full load sequence.
- rd_req  out  1  burst read request, held until rd_ack.
- rd_addr  out  24  burst start address, stable while rd_req=1.
- rd_len  out  16  burst length in words, stable while rd_req=1.
- rd_ack  in  1  request accepted.
- src_valid  in  1  read word available.
- src_data  in  16  read word.
- src_ready  out  1  controller accepts word this cycle.
- load_data  out  16  write data shared by all three RAMs.
- bird_load_en  out  1  bird RAM write enable.
- bird_load_addr  out  13  bird RAM address.
- pipe_load_en  out  1  pipe RAM write enable.
- pipe_load_addr  out  16  pipe RAM address.
- base_load_en  out  1  base RAM write enable.
- base_load_addr  out  14  base RAM address.
- busy  out  1  sequence in progress.
- tex_ready  out  1  all textures loaded; level signal.
- load_err  out  1  timeout occurred; level signal.
- done  out  1  one-cycle pulse when the sequence completes successfully.

Behaviour:
- Reset (sync, rst=1): state=IDLE. All outputs 0, including addresses, load_data, tex_ready and load_err. Word counter = 0.
- States: IDLE → REQ_BIRD → LD_BIRD → REQ_PIPE → LD_PIPE → REQ_BASE → LD_BASE → FIN → IDLE. Any REQ or LD state can also go → ERR.
- IDLE:
  - start=1 → REQ_BIRD.
  - Entering REQ_BIRD clears tex_ready, load_err and the counter, and sets busy=1.
  - start while busy is ignored.
- REQ_x:
  - rd_req=1 with rd_addr=x_SRC_ADDR and rd_len=x_WORDS (PIPE_WORDS for pipe).
  - On the rd_ack cycle: rd_req→0 next cycle, counter cleared, → LD_x.
- LD_x:
  - src_ready=1 throughout.
  - A word is accepted on each src_valid&src_ready cycle.
  - One cycle after acceptance, the x_load_en pulse asserts with x_load_addr = counter value at acceptance and load_data = src_data. Write latency is 1 cycle.
  - Counter increments per accepted word.
  - Pipe exception: pipe_load_en asserts only when counter < PIPE_KEEP. Words at counter ≥ PIPE_KEEP are accepted and discarded; pipe_load_en stays 0.
  - On acceptance of word x_WORDS-1: src_ready=0 from the next cycle, → next REQ state. The final write pulse still fires the following cycle.
- Only one load_en asserts in any cycle. Enables not being pulsed are 0.
- FIN: lasts one cycle. done=1, tex_ready=1 (held until the next start or rst), busy=0, → IDLE.
- Timeout:
  - An idle counter resets on rd_ack, on each accepted word and on state entry, and increments otherwise in REQ/LD states.
  - Reaching TIMEOUT_CYC → ERR: rd_req=0, src_ready=0, busy=0, load_err=1. tex_ready stays 0.
  - ERR → IDLE after one cycle. load_err holds until the next start.
- rst asserted mid-sequence aborts immediately with no further write pulses. The partially written RAM contents are undefined; tex_ready=0.
- rd_ack arriving in a non-REQ state is ignored. src_valid outside LD states is not accepted (src_ready=0).

Test Plan:
- Bench params BIRD_WORDS=6, PIPE_WORDS=10, PIPE_KEEP=4, BASE_WORDS=5. Checks:
  - start, immediate rd_ack, continuous src_valid with data 0..20 → bird writes at addr 0..5 with data 0..5.
  - Pipe addr 0..3 written with data 6..9; data 10..15 consumed with no pipe_load_en.
  - Base writes at addr 0..4 with data 16..20.
  - Then done pulse, tex_ready=1, busy=0.
- Bubbly src_valid (pattern 1,0,0,1) during LD_BIRD → write pulses exactly 1 cycle after each accept; addresses contiguous 0..5; no duplicate or missing writes.
- rd_ack delayed 7 cycles → rd_req, rd_addr and rd_len stable for 8 cycles; rd_req=0 the cycle after rd_ack.
- TIMEOUT_CYC=20, src_valid never asserted in LD_PIPE → load_err=1 at idle count 20, busy=0, tex_ready=0. A subsequent start clears load_err and reloads from bird.
- rst=1 while in LD_BASE at word 2 → next cycle all outputs 0 and state IDLE. start while busy in LD_BIRD → ignored; the sequence completes normally.
- Second start after tex_ready=1 → tex_ready drops the cycle REQ_BIRD is entered and rises again on the new done pulse.

Source files
------------

// File: rtl/texture_load_ctrl.sv
// Loads the bird, pipe and base textures from SDRAM into the renderer RAMs.
// It issues one burst per texture and turns the returned word stream into RAM writes.
module texture_load_ctrl #(
   parameter int          BIRD_WORDS    = 5250,
   parameter int          PIPE_WORDS    = 40000,
   parameter int          PIPE_KEEP     = 4000,
   parameter int          BASE_WORDS    = 9600,
   parameter logic [23:0] BIRD_SRC_ADDR = 24'h100000,
   parameter logic [23:0] PIPE_SRC_ADDR = 24'h102000,
   parameter logic [23:0] BASE_SRC_ADDR = 24'h10C000,
   parameter int          TIMEOUT_CYC   = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        rd_req,
   output logic [23:0] rd_addr,
   output logic [15:0] rd_len,
   input  logic        rd_ack,
   input  logic        src_valid,
   input  logic [15:0] src_data,
   output logic        src_ready,
   output logic [15:0] load_data,
   output logic        bird_load_en,
   output logic [12:0] bird_load_addr,
   output logic        pipe_load_en,
   output logic [15:0] pipe_load_addr,
   output logic        base_load_en,
   output logic [13:0] base_load_addr,
   output logic        busy,
   output logic        tex_ready,
   output logic        load_err,
   output logic        done
);

   localparam int            IW         = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYC - 1);

   typedef enum logic [3:0] {
      IDLE, REQ_BIRD, LD_BIRD, REQ_PIPE, LD_PIPE, REQ_BASE, LD_BASE, FIN, ERR
   } state_t;

   state_t        state_reg, state_next, after_state;
   logic [15:0]   cnt_reg, cnt_next;
   logic [IW-1:0] idle_reg, idle_next;
   logic          in_req, in_ld, accept, keep;
   logic [2:0]    sel;
   logic [15:0]   last;
   logic [2:0]    en_reg;
   logic [12:0]   bird_addr_reg;
   logic [15:0]   pipe_addr_reg;
   logic [13:0]   base_addr_reg;
   logic [15:0]   data_reg;
   logic          tex_ready_reg, load_err_reg;

   // Per-state burst parameters, target RAM select and successor state.
   always_comb begin
      in_req      = 1'b0;
      in_ld       = 1'b0;
      sel         = 3'b000;
      last        = 16'd0;
      after_state = IDLE;
      rd_addr     = 24'd0;
      rd_len      = 16'd0;
      case (state_reg)
         REQ_BIRD: begin
            in_req = 1'b1; rd_addr = BIRD_SRC_ADDR; rd_len = 16'(BIRD_WORDS); after_state = LD_BIRD;
         end
         LD_BIRD: begin
            in_ld = 1'b1; sel = 3'b001; last = 16'(BIRD_WORDS - 1); after_state = REQ_PIPE;
         end
         REQ_PIPE: begin
            in_req = 1'b1; rd_addr = PIPE_SRC_ADDR; rd_len = 16'(PIPE_WORDS); after_state = LD_PIPE;
         end
         LD_PIPE: begin
            in_ld = 1'b1; sel = 3'b010; last = 16'(PIPE_WORDS - 1); after_state = REQ_BASE;
         end
         REQ_BASE: begin
            in_req = 1'b1; rd_addr = BASE_SRC_ADDR; rd_len = 16'(BASE_WORDS); after_state = LD_BASE;
         end
         LD_BASE: begin
            in_ld = 1'b1; sel = 3'b100; last = 16'(BASE_WORDS - 1); after_state = FIN;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idle_next  = idle_reg;
      rd_req     = in_req;
      src_ready  = in_ld;
      accept     = in_ld && src_valid;
      // Pipe rows past the kept region are drained but never written.
      keep       = !sel[1] || (cnt_reg < 16'(PIPE_KEEP));
      case (state_reg)
         IDLE: begin
            idle_next = '0;
            if (start) begin
               state_next = REQ_BIRD;
               cnt_next   = 16'd0;
            end
         end
         FIN, ERR: begin
            state_next = IDLE;
            idle_next  = '0;
         end
         default: begin
            if ((in_req && rd_ack) || accept) begin
               idle_next = '0;
               if (in_req) begin
                  state_next = after_state;
                  cnt_next   = 16'd0;
               end else begin
                  cnt_next = cnt_reg + 16'd1;
                  if (cnt_reg == last) state_next = after_state;
               end
            end else if (idle_reg == IDLE_LIMIT) begin
               state_next = ERR;
               idle_next  = '0;
            end else begin
               idle_next = idle_reg + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 16'd0;
         idle_reg      <= '0;
         data_reg      <= 16'd0;
         en_reg        <= 3'b000;
         bird_addr_reg <= 13'd0;
         pipe_addr_reg <= 16'd0;
         base_addr_reg <= 14'd0;
         tex_ready_reg <= 1'b0;
         load_err_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idle_reg  <= idle_next;
         en_reg    <= {3{accept && keep}} & sel;
         if (accept) data_reg <= src_data;
         if (accept && keep) begin
            if (sel[0]) bird_addr_reg <= cnt_reg[12:0];
            if (sel[1]) pipe_addr_reg <= cnt_reg;
            if (sel[2]) base_addr_reg <= cnt_reg[13:0];
         end
         if (state_reg == IDLE && start) begin
            tex_ready_reg <= 1'b0;
            load_err_reg  <= 1'b0;
         end
         if (state_next == FIN) tex_ready_reg <= 1'b1;
         if (state_next == ERR) load_err_reg  <= 1'b1;
      end
   end

   assign load_data      = data_reg;
   assign bird_load_en   = en_reg[0];
   assign pipe_load_en   = en_reg[1];
   assign base_load_en   = en_reg[2];
   assign bird_load_addr = bird_addr_reg;
   assign pipe_load_addr = pipe_addr_reg;
   assign base_load_addr = base_addr_reg;
   assign busy           = in_req || in_ld;
   assign done           = (state_reg == FIN);
   assign tex_ready      = tex_ready_reg;
   assign load_err       = load_err_reg;

endmodule
